// File: rtl/pi_lane_permuter_if.sv
// pi_lane_permuter_if
// Bundles the controller-facing signals of pi_lane_permuter.
// Ports (signals):
//   load, state_in, start  - controller -> permuter (load/start honoured only in IDLE)
//   inverse                - controller -> permuter, exists only with PI_INVERSE_EN
//   busy, done, state_out  - permuter -> controller
// Lane k = 5x+y of state_in/state_out lives at bits [LANE_W*k +: LANE_W].
interface pi_lane_permuter_if #(
  parameter int unsigned LANE_W = 1
);
  logic                  load;
  logic [25*LANE_W-1:0]  state_in;
  logic                  start;
`ifdef PI_INVERSE_EN
  logic                  inverse;
`endif
  logic                  busy;
  logic                  done;
  logic [25*LANE_W-1:0]  state_out;

  modport master (
    output load, state_in, start,
`ifdef PI_INVERSE_EN
    output inverse,
`endif
    input  busy, done, state_out
  );

  modport slave (
    input  load, state_in, start,
`ifdef PI_INVERSE_EN
    input  inverse,
`endif
    output busy, done, state_out
  );
endinterface

// File: rtl/pi_lane_permuter.sv
// pi_lane_permuter
// Sequential permutation of a 5x5 state of LANE_W-bit lanes. Each pass moves one lane per
// clock with (x,y) -> (y, (2x+3y) mod 5); ROUNDS passes run back to back per start, with a
// one-cycle COPY (src <= dst) between passes. When PI_INVERSE_EN is defined an inverse
// input is latched on start and selects (x,y) -> ((x+3y) mod 5, x) instead; otherwise
// only the forward mapping exists.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-high reset (clears state, buffers and counters)
//   bus  - pi_lane_permuter_if.slave
//            load/state_in : capture state into src (IDLE only)
//            start         : begin ROUNDS passes (IDLE only)
//            inverse       : mapping select, PI_INVERSE_EN builds only
//            busy          : high in MOVE and COPY
//            done          : one-cycle pulse when the last pass has finished
//            state_out     : dst buffer, same lane packing as state_in
module pi_lane_permuter #(
  parameter int unsigned LANE_W = 1,
  parameter int unsigned ROUNDS = 1
) (
  input logic              clk,
  input logic              rst,
  pi_lane_permuter_if.slave bus
);

  localparam int unsigned Lanes   = 25;
  localparam logic [4:0]  LastRnd = 5'(ROUNDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMove,
    StCopy,
    StDone
  } state_e;

  state_e state, state_next;

  logic [LANE_W-1:0] src [Lanes];
  logic [LANE_W-1:0] dst [Lanes];
  logic [2:0]        x, y;
  logic [4:0]        rnd;
  logic              inv_q;

  logic [4:0] x5, y5;
  logic [4:0] src_idx, dst_idx;
  logic [4:0] fwd_m, inv_m;
  logic       last_lane;
  logic [25*LANE_W-1:0] out_flat;

  // Inputs never exceed 20, so three conditional subtracts reduce any of them mod 5.
  function automatic logic [4:0] mod5(input logic [4:0] v);
    logic [4:0] t;
    t = v;
    if (t >= 5'd20) t = t - 5'd20;
    if (t >= 5'd10) t = t - 5'd10;
    if (t >= 5'd5)  t = t - 5'd5;
    return t;
  endfunction

  // Lane index arithmetic, all at 5 bits.
  always_comb begin
    x5      = {2'b00, x};
    y5      = {2'b00, y};
    src_idx = (x5 << 2) + x5 + y5;
    fwd_m   = mod5((x5 << 1) + (y5 << 1) + y5);
    inv_m   = mod5(x5 + (y5 << 1) + y5);
    if (inv_q) begin
      dst_idx = (inv_m << 2) + inv_m + x5;
    end else begin
      dst_idx = (y5 << 2) + y5 + fwd_m;
    end
  end

  assign last_lane = (x == 3'd4) && (y == 3'd4);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // Next state.
  always_comb begin
    state_next = state;
    unique case (state)
      StIdle: begin
        if (bus.start) state_next = StMove;
      end
      StMove: begin
        if (last_lane) state_next = (rnd == LastRnd) ? StDone : StCopy;
      end
      StCopy: state_next = StMove;
      StDone: state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  // Buffers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < Lanes; k++) begin
        src[k] <= '0;
        dst[k] <= '0;
      end
      x   <= '0;
      y   <= '0;
      rnd <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          // Load and start may coincide; MOVE then reads the freshly loaded src.
          if (bus.load) begin
            for (int k = 0; k < Lanes; k++) begin
              src[k] <= bus.state_in[LANE_W*k +: LANE_W];
            end
          end
          if (bus.start) begin
            x   <= '0;
            y   <= '0;
            rnd <= '0;
          end
        end
        StMove: begin
          dst[dst_idx] <= src[src_idx];
          if (y == 3'd4) begin
            y <= '0;
            x <= last_lane ? 3'd0 : x + 3'd1;
          end else begin
            y <= y + 3'd1;
          end
        end
        StCopy: begin
          for (int k = 0; k < Lanes; k++) begin
            src[k] <= dst[k];
          end
          rnd <= rnd + 5'd1;
          x   <= '0;
          y   <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef PI_INVERSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (state == StIdle && bus.start) begin
      inv_q <= bus.inverse;
    end
  end
`else
  assign inv_q = 1'b0;
`endif

  always_comb begin
    out_flat = '0;
    for (int k = 0; k < Lanes; k++) begin
      out_flat[LANE_W*k +: LANE_W] = dst[k];
    end
  end

  assign bus.state_out = out_flat;
  assign bus.busy      = (state == StMove) || (state == StCopy);
  assign bus.done      = (state == StDone);

endmodule

// File: tb/tb_pi_lane_permuter.sv
// tb_pi_lane_permuter
// Directed, table-driven bench for pi_lane_permuter. Three instances:
//   dut_a LANE_W=8 ROUNDS=1, dut_b LANE_W=8 ROUNDS=24, dut_c LANE_W=1 ROUNDS=2.
// Inverse-mode checks are built only when PI_INVERSE_EN is defined.
module tb_pi_lane_permuter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  pi_lane_permuter_if #(.LANE_W(8)) ifa ();
  pi_lane_permuter_if #(.LANE_W(8)) ifb ();
  pi_lane_permuter_if #(.LANE_W(1)) ifc ();

  pi_lane_permuter #(.LANE_W(8), .ROUNDS(1))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pi_lane_permuter #(.LANE_W(8), .ROUNDS(24)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  pi_lane_permuter #(.LANE_W(1), .ROUNDS(2))  dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Reference mappings on 25 byte lanes.
  function automatic logic [199:0] pi_fwd(input logic [199:0] s);
    logic [199:0] d;
    d = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        d[8*(5*y + (2*x + 3*y) % 5) +: 8] = s[8*(5*x + y) +: 8];
    return d;
  endfunction

  function automatic logic [199:0] pi_inv(input logic [199:0] s);
    logic [199:0] d;
    d = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        d[8*(5*((x + 3*y) % 5) + x) +: 8] = s[8*(5*x + y) +: 8];
    return d;
  endfunction

  function automatic logic [199:0] widen1(input logic [24:0] b);
    logic [199:0] d;
    d = '0;
    for (int k = 0; k < 25; k++) d[8*k] = b[k];
    return d;
  endfunction

  function automatic logic [24:0] narrow1(input logic [199:0] s);
    logic [24:0] b;
    for (int k = 0; k < 25; k++) b[k] = s[8*k];
    return b;
  endfunction

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Runs one dut_a operation starting at a negedge; returns the result seen with done and
  // the cycle (counted from the accepting edge) in which done appeared, -1 if never.
  // Ends at a negedge in the first IDLE cycle after done.
  task automatic run_a(input logic [199:0] din, input logic same, input logic inv,
                       output logic [199:0] res, output int dcyc);
    ifa.state_in = din;
    ifa.load     = 1'b1;
    if (!same) begin
      @(negedge clk);
      ifa.load = 1'b0;
    end
`ifdef PI_INVERSE_EN
    ifa.inverse = inv;
`else
    if (inv) $display("inverse requested without PI_INVERSE_EN");
`endif
    ifa.start = 1'b1;
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    ifa.load  = 1'b0;
    dcyc = -1;
    res  = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ifa.done) begin
        dcyc = n;
        res  = ifa.state_out;
        break;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [199:0] din;
    logic         same;
    logic [199:0] exp;
  } vec_t;

  vec_t         vecs [4];
  logic [199:0] res  [4];
  logic [199:0] ramp, tmp, got, rs, hand;
  int           dcyc, first, cnt;
  logic         busy26, done26, done52;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.load = 0; ifa.start = 0; ifa.state_in = '0;
    ifb.load = 0; ifb.start = 0; ifb.state_in = '0;
    ifc.load = 0; ifc.start = 0; ifc.state_in = '0;
`ifdef PI_INVERSE_EN
    ifa.inverse = 0; ifb.inverse = 0; ifc.inverse = 0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", 200'(ifa.busy), 200'd0);
    check("reset done", 200'(ifa.done), 200'd0);
    check("reset state_out", ifa.state_out, '0);
    check("reset b busy", 200'(ifb.busy), 200'd0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int k = 0; k < 25; k++) ramp[8*k +: 8] = 8'(k);
    hand = '0;
    hand[8*13 +: 8] = 8'h5A;  // src lane 7 = (1,2) -> (2,3) = lane 13
    vecs[0] = '{din: ramp, same: 1'b0, exp: pi_fwd(ramp)};
    for (int k = 0; k < 25; k++) tmp[8*k +: 8] = 8'hA0 + 8'(k);
    vecs[1] = '{din: tmp, same: 1'b1, exp: pi_fwd(tmp)};
    tmp = '0;
    tmp[8*7 +: 8] = 8'h5A;
    vecs[2] = '{din: tmp, same: 1'b0, exp: hand};
    for (int k = 0; k < 25; k++) tmp[8*k +: 8] = 8'hFF - 8'(k);
    vecs[3] = '{din: tmp, same: 1'b1, exp: pi_fwd(tmp)};

    for (int i = 0; i < 4; i++) begin
      run_a(vecs[i].din, vecs[i].same, 1'b0, res[i], dcyc);
      check($sformatf("vec%0d done cycle", i), 200'(dcyc), 200'd26);
      check($sformatf("vec%0d result", i), res[i], vecs[i].exp);
      check($sformatf("vec%0d idle hold", i), ifa.state_out, vecs[i].exp);
    end
    check("ramp lane2", 200'(res[0][8*2 +: 8]), 200'd5);
    check("ramp lane8", 200'(res[0][8*8 +: 8]), 200'd1);
    check("ramp lane0", 200'(res[0][8*0 +: 8]), 200'd0);
    check("load+start lane2", 200'(res[1][8*2 +: 8]), 200'hA5);

    // Reset mid-MOVE
    ifa.state_in = ramp; ifa.load = 1'b1; ifa.start = 1'b1;
    @(posedge clk);
    #1;
    ifa.load = 1'b0; ifa.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midmove rst busy", 200'(ifa.busy), 200'd0);
    check("midmove rst done", 200'(ifa.done), 200'd0);
    check("midmove rst state_out", ifa.state_out, '0);
    rst = 1'b0;
    @(negedge clk);
    run_a(ramp, 1'b1, 1'b0, got, dcyc);
    check("after rst done cycle", 200'(dcyc), 200'd26);
    check("after rst result", got, pi_fwd(ramp));

    // 24 rounds restore the state; start pulses while busy are ignored
    for (int k = 0; k < 25; k++) rs[8*k +: 8] = 8'($urandom);
    ifb.state_in = rs; ifb.load = 1'b1; ifb.start = 1'b1;
    @(posedge clk);
    #1;
    ifb.load = 1'b0; ifb.start = 1'b0;
    first = -1; cnt = 0; got = '0;
    for (int n = 1; n <= 700; n++) begin
      @(negedge clk);
      if (ifb.done) begin
        cnt++;
        if (first < 0) begin
          first = n;
          got   = ifb.state_out;
        end
      end
      ifb.start = (n == 100 || n == 300 || n == 624);
    end
    ifb.start = 1'b0;
    check("r24 done cycle", 200'(first), 200'd624);
    check("r24 done count", 200'(cnt), 200'd1);
    check("r24 result", got, rs);
    check("r24 idle busy", 200'(ifb.busy), 200'd0);

    // LANE_W=1, ROUNDS=2 walking one
    for (int p = 0; p < 25; p++) begin
      ifc.state_in = 25'd1 << p; ifc.load = 1'b1; ifc.start = 1'b1;
      @(posedge clk);
      #1;
      ifc.load = 1'b0; ifc.start = 1'b0;
      busy26 = 1'b0; done26 = 1'b1; done52 = 1'b0; got = '0;
      for (int n = 1; n <= 52; n++) begin
        @(negedge clk);
        if (n == 26) begin
          busy26 = ifc.busy;
          done26 = ifc.done;
        end
        if (n == 52) begin
          done52 = ifc.done;
          got    = 200'(ifc.state_out);
        end
      end
      @(negedge clk);
      check($sformatf("w1 p%0d copy busy", p), 200'(busy26), 200'd1);
      check($sformatf("w1 p%0d copy no done", p), 200'(done26), 200'd0);
      check($sformatf("w1 p%0d done 52", p), 200'(done52), 200'd1);
      check($sformatf("w1 p%0d result", p), got,
            200'(narrow1(pi_fwd(pi_fwd(widen1(25'd1 << p))))));
    end

`ifdef PI_INVERSE_EN
    // Inverse mode
    run_a(ramp, 1'b0, 1'b1, got, dcyc);
    check("inv done cycle", 200'(dcyc), 200'd26);
    check("inv lane1", 200'(got[8*1 +: 8]), 200'd8);
    check("inv lane0", 200'(got[8*0 +: 8]), 200'd0);
    check("inv result", got, pi_inv(ramp));
    run_a(pi_fwd(ramp), 1'b1, 1'b1, got, dcyc);
    check("inv undo fwd", got, ramp);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pi_lane_permuter.md
# pi_lane_permuter

Sequential lane-permutation engine for a 5x5 state of `LANE_W`-bit lanes. It applies the mapping (x,y) -> (y, (2x+3y) mod 5) one lane per cycle, repeated for `ROUNDS` back-to-back passes. It generalises the single-bit 5x5 index-walk datapath to arbitrary lane width, multi-round operation and an optional inverse mode. It sits between the state-load logic and downstream round logic, and is controlled by a start/done handshake from the top-level controller.

## Interface
- `LANE_W`, 1: bits per lane; the state is 25*`LANE_W` bits.
- `ROUNDS`, 1: permutation passes per start, valid range 1..31.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load` input 1: capture `state_in` into the source buffer; honoured only in IDLE.
- `state_in` input 25*`LANE_W`: lane k = 5x+y occupies bits [`LANE_W`*k +: `LANE_W`].
- `start` input 1: begin permutation; honoured only in IDLE.
- `inverse` input 1: sampled with `start`. Present only with `PI_INVERSE_EN`.
- `busy` output 1: high in MOVE and COPY.
- `done` output 1: one-cycle pulse in DONE.
- `state_out` output 25*`LANE_W`: destination buffer, always driven, same lane packing as `state_in`.

## Operation
- Storage:
  - `src`: 25 lanes, source buffer.
  - `dst`: 25 lanes, destination buffer.
  - `x`, `y`: 3-bit lane counters.
  - `rnd`: 5-bit round counter.
  - `inv_q`: latched `inverse` bit.
- States: IDLE, MOVE, COPY, DONE.
- IDLE:
  - `load`=1 sets `src` <= `state_in`.
  - `start`=1 moves to MOVE with x=0, y=0, rnd=0, and `inv_q` <= `inverse`.
  - `load` and `start` in the same cycle: both take effect. The first MOVE cycle reads the newly loaded `src`.
- MOVE, one lane per cycle:
  - Forward: `dst`[5y + ((2x+3y) mod 5)] <= `src`[5x+y].
  - Inverse: `dst`[5((x+3y) mod 5) + x] <= `src`[5x+y].
  - Index arithmetic: compute all intermediate values at 5 bits, then reduce mod 5 with a compare/subtract chain. No divider.
  - Walk order is row-major: y increments 0..4, wraps to 0, and x increments.
  - At (4,4): if rnd == `ROUNDS`-1, go to DONE; otherwise go to COPY.
- COPY, one cycle: `src` <= `dst`, rnd++, x=y=0, then back to MOVE.
- DONE, one cycle: `done`=1, then return to IDLE. `dst` holds the result until the next MOVE overwrites lanes.
- While not IDLE, `start` and `load` are ignored (no queueing).
- Reset takes priority over everything, including mid-MOVE or mid-COPY. Reset forces:
  - state IDLE;
  - `src`, `dst`, x, y, rnd, `inv_q` all 0;
  - `busy`=0, `done`=0, `state_out`=0.
- Every destination index is written exactly once per pass, because the mapping is a bijection, so no stale lanes remain after a pass.

## Timing
- Start accepted at edge E0. MOVE occupies cycles 1..25 of each round, and COPY adds one cycle between rounds.
- `done` is high in cycle 26*`ROUNDS` after E0.
- `busy` rises in the cycle after E0 and falls when DONE is entered.
- `state_out` is final when `done` is high and stays stable in IDLE.
- A new `start` is accepted in the first IDLE cycle after DONE, so the minimum start-to-start spacing is 26*`ROUNDS`+1 cycles.
- `src`/`dst` updates are registered; reads are combinational lane muxes from `src`.

## Configuration
- `PI_INVERSE_EN`:
  - Defined: the `inverse` port exists and is latched on start. `inverse`=1 applies (x,y) -> ((x+3y) mod 5, x) each round, which undoes the forward mapping.
  - Undefined: the port is absent, `inv_q` is tied to 0, and only the forward mapping is synthesised.

## Test plan
- Reset mid-MOVE: assert `rst` in cycle 10 after start. Next cycle: `busy`=0, `done`=0, `state_out`=0. A subsequent load+start completes normally.
- Forward single round, `LANE_W`=8, lane k = k:
  - Expected: `done` in cycle 26; `state_out` lane 2 = 5, lane 8 = 1, lane 0 = 0.
  - Full result checked against a software model.
- Simultaneous load+start in IDLE with new data (lane k = 0xA0+k): result uses the new data, e.g. lane 2 = 0xA5.
- `ROUNDS`=24, random state: `done` in cycle 624 and `state_out` == `state_in`. Also confirm `start` pulses during `busy` are ignored (exactly one `done`).
- `PI_INVERSE_EN`, inverse=1, lane k = k:
  - Expected: lane 1 = 8, lane 0 = 0.
  - Feeding the forward result back with inverse=1 restores the original state.
- `LANE_W`=1, `ROUNDS`=2, walking-one across all 25 positions: each result matches the composition of two forward passes. COPY is observed as `busy`=1 in cycle 26 with no `done`.
